// File: rtl/pinbus_arbiter.sv
// Two-requester round-robin arbiter that serialises transfers onto an 8-bit pin bus.
// Optional macro PINBUS_WAIT_EN: data phases stall on ext_rdy=0.
module pinbus_arbiter #(
   parameter int TURN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] rdata,
   output logic        busy,
   output logic [7:0]  pin_out,
   output logic [7:0]  pin_io_out,
   output logic [7:0]  pin_io_oe,
   input  logic [7:0]  pin_io_in,
   input  logic        ext_rdy
);

   typedef enum logic [3:0] {
      IDLE, A0, A1, A2, A3, CMD, TA, D0, D1, D2, D3, DONE
   } state_t;

   state_t      state, state_nxt;
   logic        last_gid, gid, xfer_we, grant_id, any_req, d_adv, ta_last;
   logic [31:0] xfer_addr, xfer_wdata;
   logic [1:0]  ta_cnt;
   logic [7:0]  cmd_byte, wr_oe;

   function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
      return word[8*idx +: 8];
   endfunction

   assign any_req  = req0 | req1;
   // On contention the requester not granted last time wins.
   assign grant_id = (req0 & req1) ? ~last_gid : req1;
   assign cmd_byte = {6'b0, gid, xfer_we};
   assign wr_oe    = {8{xfer_we}};
   assign busy     = (state != IDLE);
   assign ta_last  = (ta_cnt == 2'(TURN - 1));

`ifdef PINBUS_WAIT_EN
   assign d_adv = ext_rdy;
`else
   logic unused_ext_rdy;
   assign unused_ext_rdy = ext_rdy;
   assign d_adv = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_gid <= 1'b1;
         ta_cnt   <= 2'd0;
         rdata    <= 32'h0;
      end else begin
         state  <= state_nxt;
         ta_cnt <= (state == TA) ? ta_cnt + 2'd1 : 2'd0;
         if (state == IDLE && any_req)
            last_gid <= grant_id;
         // Read bytes land in rdata at the edge that leaves each data phase.
         if (!xfer_we && d_adv) begin
            case (state)
               D0:      rdata[7:0]   <= pin_io_in;
               D1:      rdata[15:8]  <= pin_io_in;
               D2:      rdata[23:16] <= pin_io_in;
               D3:      rdata[31:24] <= pin_io_in;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && any_req) begin
         gid        <= grant_id;
         xfer_we    <= grant_id ? we1 : we0;
         xfer_addr  <= grant_id ? addr1 : addr0;
         xfer_wdata <= grant_id ? wdata1 : wdata0;
      end
   end

   always_comb begin
      state_nxt  = state;
      pin_out    = 8'h00;
      pin_io_out = 8'h00;
      pin_io_oe  = 8'h00;
      done0      = 1'b0;
      done1      = 1'b0;
      case (state)
         IDLE: if (any_req) state_nxt = A0;
         A0: begin
            pin_out   = byte_of(xfer_addr, 2'd0);
            state_nxt = A1;
         end
         A1: begin
            pin_out   = byte_of(xfer_addr, 2'd1);
            state_nxt = A2;
         end
         A2: begin
            pin_out   = byte_of(xfer_addr, 2'd2);
            state_nxt = A3;
         end
         A3: begin
            pin_out   = byte_of(xfer_addr, 2'd3);
            state_nxt = CMD;
         end
         CMD: begin
            pin_out   = cmd_byte;
            pin_io_oe = wr_oe;
            state_nxt = (!xfer_we && TURN != 0) ? TA : D0;
         end
         TA: begin
            pin_out = cmd_byte;
            if (ta_last) state_nxt = D0;
         end
         D0: begin
            pin_out    = cmd_byte;
            pin_io_out = byte_of(xfer_wdata, 2'd0) & wr_oe;
            pin_io_oe  = wr_oe;
            if (d_adv) state_nxt = D1;
         end
         D1: begin
            pin_out    = cmd_byte;
            pin_io_out = byte_of(xfer_wdata, 2'd1) & wr_oe;
            pin_io_oe  = wr_oe;
            if (d_adv) state_nxt = D2;
         end
         D2: begin
            pin_out    = cmd_byte;
            pin_io_out = byte_of(xfer_wdata, 2'd2) & wr_oe;
            pin_io_oe  = wr_oe;
            if (d_adv) state_nxt = D3;
         end
         D3: begin
            pin_out    = cmd_byte;
            pin_io_out = byte_of(xfer_wdata, 2'd3) & wr_oe;
            pin_io_oe  = wr_oe;
            if (d_adv) state_nxt = DONE;
         end
         DONE: begin
            done0     = ~gid;
            done1     = gid;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pinbus_arbiter.sv
// Bench for pinbus_arbiter: directed table, corner sequences and randomized traffic
// checked every cycle against a transaction-trace reference model.
module tb_pinbus_arbiter;
   localparam int TURN = 1;

   logic        clk = 1'b0;
   logic        rst_n, req0, req1, we0, we1, ext_rdy;
   logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
   logic [7:0]  pin_io_in, pin_out, pin_io_out, pin_io_oe;
   logic        done0, done1, busy;

   pinbus_arbiter #(.TURN(TURN)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
      .pin_out(pin_out), .pin_io_out(pin_io_out), .pin_io_oe(pin_io_oe),
      .pin_io_in(pin_io_in), .ext_rdy(ext_rdy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // One expected bus cycle; rd = byte captured at its end (-1 none), dw = data phase.
   typedef struct {
      logic [7:0] po, pio, oe;
      logic       d0, d1, busy;
      int         rd;
      bit         dw;
   } cyc_t;

   cyc_t        q[$];
   cyc_t        cur;
   bit          last_g;
   bit          started = 0;
   logic [31:0] exp_rdata;

   function automatic cyc_t mk(logic [7:0] po, logic [7:0] pio, logic [7:0] oe,
                               logic d0, logic d1, logic b, int rd, bit dw);
      cyc_t c;
      c.po = po; c.pio = pio; c.oe = oe; c.d0 = d0; c.d1 = d1; c.busy = b;
      c.rd = rd; c.dw = dw;
      return c;
   endfunction

   // Whole transfer as a list of cycles: 4 address bytes, command, turnaround (reads),
   // 4 data bytes, done, then the mandatory idle cycle.
   function automatic void push_trace(bit g, bit we, logic [31:0] a, logic [31:0] w);
      logic [7:0] cmd, oe;
      cmd = {6'b0, g, we};
      oe  = we ? 8'hFF : 8'h00;
      for (int i = 0; i < 4; i++) q.push_back(mk(a[8*i +: 8], 8'h00, 8'h00, 0, 0, 1, -1, 0));
      q.push_back(mk(cmd, 8'h00, oe, 0, 0, 1, -1, 0));
      if (!we) for (int i = 0; i < TURN; i++) q.push_back(mk(cmd, 8'h00, 8'h00, 0, 0, 1, -1, 0));
      for (int i = 0; i < 4; i++)
         q.push_back(mk(cmd, we ? w[8*i +: 8] : 8'h00, oe, 0, 0, 1, we ? -1 : i, 1));
      q.push_back(mk(8'h00, 8'h00, 8'h00, !g, g, 1, -1, 0));
      q.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 0, -1, 0));
   endfunction

   task automatic model_update();
      bit hold, g;
      if (!rst_n) begin
         q.delete();
         last_g    = 1'b1;
         exp_rdata = 32'h0;
         cur       = mk(0, 0, 0, 0, 0, 0, -1, 0);
      end else begin
         hold = 1'b0;
`ifdef PINBUS_WAIT_EN
         if (cur.dw && !ext_rdy) hold = 1'b1;
`endif
         if (!hold && cur.rd >= 0) exp_rdata[8*cur.rd +: 8] = pin_io_in;
         if (!hold) begin
            if (q.size() == 0) begin
               if (req0 || req1) begin
                  g      = (req0 && req1) ? !last_g : req1;
                  last_g = g;
                  push_trace(g, g ? we1 : we0, g ? addr1 : addr0, g ? wdata1 : wdata0);
                  cur = q.pop_front();
               end else begin
                  cur = mk(0, 0, 0, 0, 0, 0, -1, 0);
               end
            end else begin
               cur = q.pop_front();
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      started = 1;
      @(negedge clk);
      check("cycle", {5'b0, pin_out, pin_io_out, pin_io_oe, done0, done1, busy, rdata},
            {5'b0, cur.po, cur.pio, cur.oe, cur.d0, cur.d1, cur.busy, exp_rdata});
   endtask

   typedef struct {
      bit          id;
      bit          we;
      logic [31:0] addr, wdata, rin;
      int          lat;
      logic [31:0] rdata_exp;
      logic [7:0]  cmd;
   } vec_t;

   vec_t vt[4];

   task automatic run_vec(input vec_t v);
      int         lat;
      logic [7:0] cmd_seen;
      bit         other;
      lat = -1; cmd_seen = 8'h00; other = 0;
      if (v.id) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
      else      begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
      for (int n = 1; n <= 30; n++) begin
         step();
         if (n == 1) begin
            req0 = 0; req1 = 0; we0 = $urandom; we1 = $urandom;
            addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
         end
         if (n == 5) cmd_seen = pin_out;
         if (v.id ? done0 : done1) other = 1;
         if ((v.id ? done1 : done0) && lat < 0) lat = n;
         pin_io_in = (n >= 6 + TURN && n <= 9 + TURN) ? v.rin[8*(n-6-TURN) +: 8] : 8'($urandom);
         if (lat >= 0) break;
      end
      check("cmd_byte", 64'(cmd_seen), 64'(v.cmd));
      check("done_latency", 64'(lat), 64'(v.lat));
      check("other_done", 64'(other), 64'(0));
      if (!v.we) check("rdata", 64'(rdata), 64'(v.rdata_exp));
      step();
   endtask

   initial begin
      int lat, dcount, exp_lat;
      logic [7:0] hold9, exp9;
      int order[$];
      int when[$];

      rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; ext_rdy = 1;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pin_io_in = 0;
      cur = mk(0, 0, 0, 0, 0, 0, -1, 0); last_g = 1; exp_rdata = 0;

      vt[0] = '{id:0, we:1, addr:32'h12345678, wdata:32'hCAFEBABE, rin:32'h0,
                lat:10, rdata_exp:32'h0, cmd:8'h01};
      vt[1] = '{id:1, we:0, addr:32'h00000010, wdata:32'h0, rin:32'hD4C3B2A1,
                lat:10 + TURN, rdata_exp:32'hD4C3B2A1, cmd:8'h02};
      vt[2] = '{id:0, we:0, addr:32'hDEADBEEF, wdata:32'h0, rin:32'h11223344,
                lat:10 + TURN, rdata_exp:32'h11223344, cmd:8'h00};
      vt[3] = '{id:1, we:1, addr:32'hA5A50F0F, wdata:32'h01020304, rin:32'h0,
                lat:10, rdata_exp:32'h0, cmd:8'h03};

      step(); step();
      rst_n = 1;
      step();

      foreach (vt[i]) run_vec(vt[i]);

      // Data-phase stall: ext_rdy low at three consecutive D2 edges.
      req0 = 1; we0 = 1; addr0 = 32'h0BADF00D; wdata0 = 32'h44332211;
      lat = -1; hold9 = 8'h00;
      for (int n = 1; n <= 30; n++) begin
         step();
         if (n == 1) req0 = 0;
         if (n == 9) hold9 = pin_io_out;
         if (done0 && lat < 0) lat = n;
         ext_rdy = !(n >= 8 && n <= 10);
         if (lat >= 0) break;
      end
      ext_rdy = 1;
`ifdef PINBUS_WAIT_EN
      exp_lat = 13; exp9 = 8'h33;
`else
      exp_lat = 10; exp9 = 8'h44;
`endif
      check("wait_latency", 64'(lat), 64'(exp_lat));
      check("wait_d2_hold", 64'(hold9), 64'(exp9));
      step();

      // Reset during D1 of a write.
      req0 = 1; we0 = 1; addr0 = 32'h01020304; wdata0 = 32'h55667788;
      for (int n = 1; n <= 7; n++) begin
         step();
         if (n == 1) req0 = 0;
      end
      rst_n = 0;
      step();
      check("reset_outputs", {5'b0, pin_out, pin_io_out, pin_io_oe, done0, done1, busy, rdata}, 64'h0);
      rst_n = 1;
      dcount = 0;
      for (int n = 0; n < 12; n++) begin
         step();
         if (done0 || done1) dcount++;
      end
      check("no_done_after_reset", 64'(dcount), 64'(0));
      req0 = 1; addr0 = 32'hAABBCC77;
      step();
      check("restart_a0", 64'(pin_out), 64'h77);
      req0 = 0;
      for (int n = 0; n < 20 && busy; n++) step();
      step();

      // Contention after reset: grants alternate starting with requester 0.
      rst_n = 0;
      step();
      rst_n = 1; req0 = 1; req1 = 1; we0 = 1; we1 = 1;
      addr0 = 32'h10000000; addr1 = 32'h20000000; wdata0 = 32'hA0A0A0A0; wdata1 = 32'hB1B1B1B1;
      for (int n = 1; n <= 100 && order.size() < 4; n++) begin
         step();
         if (done0) begin order.push_back(0); when.push_back(n); end
         if (done1) begin order.push_back(1); when.push_back(n); end
         if (order.size() == 4) begin req0 = 0; req1 = 0; end
      end
      req0 = 0; req1 = 0;
      check("grant_count", 64'(order.size()), 64'(4));
      if (order.size() == 4) begin
         check("first_done", 64'(when[0]), 64'(10));
         for (int i = 0; i < 4; i++) check("grant_order", 64'(order[i]), 64'(i % 2));
         for (int i = 1; i < 4; i++) check("grant_gap", 64'(when[i] - when[i-1]), 64'(11));
      end
      step(); step();

      // Randomized traffic, occasional resets.
      for (int c = 0; c < 1500; c++) begin
         req0 = ($urandom % 3) != 0; req1 = ($urandom % 3) != 0;
         we0 = $urandom; we1 = $urandom;
         addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
         pin_io_in = 8'($urandom);
         ext_rdy = ($urandom % 4) != 0;
         rst_n = ($urandom % 200) != 0;
         step();
      end
      rst_n = 1; req0 = 0; req1 = 0; ext_rdy = 1;
      for (int n = 0; n < 20; n++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
